fetch_unit: RTL and testbench

Instruction fetch stage with a small prefetch queue. It sits between the instruction memory and the IF/ID pipeline register, issuing sequential fetch requests and buffering returned instructions with their PCs. It honours hazard stalls from the ID stage and discards stale instructions on a taken-branch flush, redirecting fetch to the branch target.

---
 rtl/fetch_unit_pkg.sv | 20 ++
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int unsigned Xlen = 32;
  localparam logic [Xlen-1:0] InstrNop = 32'h0000_0013;
  localparam logic [Xlen-1:0] PcStep = 32'd4;
  localparam logic [Xlen-1:0] DefaultResetPc = 32'h0000_0000;

  // One prefetch queue slot: instruction tagged with the PC it was fetched from.
  typedef struct packed {
    logic [Xlen-1:0] pc;
    logic [Xlen-1:0] instr;
  } fetch_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [Xlen-1:0] align_word(logic [Xlen-1:0] addr);
    return {addr[Xlen-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response channel between fetch and imem.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic            req;
  logic [Xlen-1:0] addr;
  logic            valid;
  logic [Xlen-1:0] instr;

  // Fetch side issues requests and consumes in-order responses.
  modport master (
    output req,
    output addr,
    input  valid,
    input  instr
  );

  // Memory side.
  modport slave (
    input  req,
    input  addr,
    output valid,
    output instr
  );

endinterface

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of {pc, instr} entries with push/pop/clear and occupancy count.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic                         push_i,
  input  fetch_entry_t                 wdata_i,
  input  logic                         pop_i,
  output fetch_entry_t                 rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  fetch_entry_t    mem_q [DEPTH];
  fetch_entry_t    mem_d [DEPTH];

  // Pointer, count and storage next-state; clear wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push_i && !pop_i) begin
        count_d = count_q + 1'b1;
      end else if (!push_i && pop_i) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: slots are only read when count_q says they are valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited sequential fetch into a prefetch queue,
// with stall hold and flush/redirect that discards stale in-flight responses.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [Xlen-1:0] RESET_PC = DefaultResetPc
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  fetch_unit_if.master    imem,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [Xlen-1:0] redirect_pc_i,
  output logic            instr_valid_o,
  output logic [Xlen-1:0] instr_o,
  output logic [Xlen-1:0] pc_o
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  typedef logic [CntW-1:0] cnt_t;
  typedef logic [CntW+1:0] sum_t;

  logic [Xlen-1:0] fetch_pc_q, fetch_pc_d;
  logic [Xlen-1:0] ret_pc_q, ret_pc_d;
  cnt_t            outstanding_q, outstanding_d;
  cnt_t            discard_q, discard_d;
  cnt_t            fifo_count;
  sum_t            credit_used;
  logic            req;
  logic            push;
  logic            pop;
  logic            fifo_nonempty;
  logic [Xlen-1:0] target_pc;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;

  assign target_pc     = align_word(redirect_pc_i);
  assign fifo_nonempty = (fifo_count != '0);

  // Every issued request already owns a queue slot, so the queue cannot overflow.
  assign credit_used = sum_t'(fifo_count) + sum_t'(outstanding_q) + sum_t'(discard_q);
  assign req         = rst_i & start_i & ~flush_i & (credit_used < sum_t'(DEPTH));
  assign pop         = instr_valid_o & ~stall_i & ~flush_i;

  // Responses carry no address; their PC comes from a counter that advances per accepted one.
  assign push_entry = '{pc: ret_pc_q, instr: imem.instr};

  // Counter, fetch PC and return PC next-state; flush overrides normal bookkeeping.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    ret_pc_d      = ret_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    push          = 1'b0;
    if (flush_i) begin
      // A response arriving now is one of the in-flight ones and is dropped here.
      discard_d     = discard_q + outstanding_q - cnt_t'(imem.valid);
      outstanding_d = '0;
      fetch_pc_d    = target_pc;
      ret_pc_d      = target_pc;
    end else begin
      if (imem.valid) begin
        if (discard_q != '0) begin
          discard_d = discard_q - 1'b1;
        end else begin
          push          = 1'b1;
          outstanding_d = outstanding_d - 1'b1;
          ret_pc_d      = ret_pc_q + PcStep;
        end
      end
      if (req) begin
        outstanding_d = outstanding_d + 1'b1;
        fetch_pc_d    = fetch_pc_q + PcStep;
      end
    end
  end

  // Fetch state registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      fetch_pc_q    <= RESET_PC;
      ret_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      ret_pc_q      <= ret_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (flush_i),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (fifo_count)
  );

  // Output drive; reset forces the idle values regardless of stored state.
  always_comb begin
    imem.req      = req;
    imem.addr     = RESET_PC;
    instr_valid_o = 1'b0;
    instr_o       = InstrNop;
    pc_o          = '0;
    if (rst_i) begin
      imem.addr = fetch_pc_q;
      if (fifo_nonempty) begin
        instr_valid_o = 1'b1;
        instr_o       = head.instr;
        pc_o          = head.pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order latency memory model plus a queue-based reference model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  fetch_unit_if imem ();

  fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .imem          (imem),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory model: pending responses in request order.
  typedef struct {
    int unsigned due;
    logic [31:0] instr;
  } mem_item_t;
  mem_item_t mem_q[$];
  int unsigned last_due = 0;
  int unsigned lat_min = 1;
  int unsigned lat_extra = 0;
  int unsigned cyc = 0;

  // Reference model: visible queue and list of in-flight fetches marked stale on flush.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;
  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } flight_t;
  ent_t        mq[$];
  flight_t     inflight[$];
  logic [31:0] m_pc = RESET_PC;

  int n_tests = 0;
  int n_fail = 0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive memory response, check outputs, advance models, step the clock.
  task automatic cycle();
    logic        exp_req;
    bit          do_pop;
    int unsigned due;
    flight_t     f;
    imem.valid = 1'b0;
    imem.instr = $urandom;
    if (rst_i && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem.valid = 1'b1;
      imem.instr = mem_q[0].instr;
    end
    #1;
    exp_req = rst_i && start_i && !flush_i && ((mq.size() + inflight.size()) < DEPTH);
    check32("imem_req", {31'b0, imem.req}, {31'b0, exp_req});
    check32("imem_addr", imem.addr, rst_i ? m_pc : RESET_PC);
    check32("instr_valid", {31'b0, instr_valid_o}, {31'b0, (rst_i && mq.size() > 0)});
    check32("instr", instr_o, (rst_i && mq.size() > 0) ? mq[0].instr : InstrNop);
    check32("pc", pc_o, (rst_i && mq.size() > 0) ? mq[0].pc : 32'h0);

    if (imem.valid) void'(mem_q.pop_front());
    if (imem.req) begin
      due = cyc + lat_min + $urandom_range(0, lat_extra);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_q.push_back('{due: due, instr: $urandom});
    end

    if (!rst_i) begin
      mq.delete();
      inflight.delete();
      mem_q.delete();
      last_due = 0;
      m_pc = RESET_PC;
    end else begin
      do_pop = (mq.size() > 0) && !stall_i && !flush_i;
      if (do_pop) void'(mq.pop_front());
      if (imem.valid && inflight.size() > 0) begin
        f = inflight.pop_front();
        if (!flush_i && !f.stale) mq.push_back('{pc: f.addr, instr: imem.instr});
      end
      if (flush_i) begin
        mq.delete();
        foreach (inflight[i]) inflight[i].stale = 1'b1;
        m_pc = {redirect_pc_i[31:2], 2'b00};
      end else if (exp_req) begin
        inflight.push_back('{addr: m_pc, stale: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_i   = 1'b0;
    start_i = 1'b0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    cycle();
    cycle();
    rst_i = 1'b1;
  endtask

  initial begin
    @(posedge clk_i);
    #1;

    // Streaming fetch with L=1: first output two cycles after first request.
    lat_min = 1; lat_extra = 0;
    do_reset();
    check32("rst_valid", {31'b0, instr_valid_o}, 32'h0);
    check32("rst_instr", instr_o, InstrNop);
    start_i = 1'b1;
    cycle();
    cycle();
    check32("s1_first_valid", {31'b0, instr_valid_o}, 32'h1);
    check32("s1_pc0", pc_o, 32'h0);
    cycle();
    check32("s1_pc4", pc_o, 32'h4);
    cycle();
    check32("s1_pc8", pc_o, 32'h8);
    repeat (8) cycle();

    // Stall held: queue fills, requests stop, head held.
    do_reset();
    start_i = 1'b1;
    stall_i = 1'b1;
    repeat (6) cycle();
    check32("s2_req_blocked", {31'b0, imem.req}, 32'h0);
    check32("s2_head_pc", pc_o, 32'h0);
    stall_i = 1'b0;
    repeat (8) cycle();

    // Mid-stream reset.
    rst_i = 1'b0;
    cycle();
    check32("s6_valid", {31'b0, instr_valid_o}, 32'h0);
    check32("s6_addr", imem.addr, RESET_PC);
    check32("s6_instr", instr_o, InstrNop);
    rst_i = 1'b1;

    // L=3 flush with two fetches in flight.
    lat_min = 3; lat_extra = 0;
    do_reset();
    start_i = 1'b1;
    cycle();
    cycle();
    flush_i = 1'b1;
    redirect_pc_i = 32'h0000_0100;
    cycle();
    flush_i = 1'b0;
    for (int i = 0; i < 20 && !instr_valid_o; i++) cycle();
    check32("s3_valid", {31'b0, instr_valid_o}, 32'h1);
    check32("s3_target_pc", pc_o, 32'h0000_0100);
    repeat (4) cycle();

    // Flush coincident with a response and a stall.
    lat_min = 1; lat_extra = 0;
    do_reset();
    start_i = 1'b1;
    stall_i = 1'b1;
    cycle();
    cycle();
    flush_i = 1'b1;
    redirect_pc_i = 32'h0000_0040;
    cycle();
    flush_i = 1'b0;
    check32("s4_empty", {31'b0, instr_valid_o}, 32'h0);
    check32("s4_addr", imem.addr, 32'h0000_0040);
    stall_i = 1'b0;
    repeat (6) cycle();

    // start_i low with two in flight, then redirect to the top word and wrap.
    lat_min = 3; lat_extra = 0;
    do_reset();
    start_i = 1'b1;
    cycle();
    cycle();
    start_i = 1'b0;
    stall_i = 1'b1;
    repeat (6) cycle();
    check32("s5_no_new_req_addr", imem.addr, 32'h8);
    check32("s5_head_pc", pc_o, 32'h0);
    stall_i = 1'b0;
    start_i = 1'b1;
    flush_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    cycle();
    flush_i = 1'b0;
    check32("s5_redirect_addr", imem.addr, 32'hFFFF_FFFC);
    cycle();
    check32("s5_wrap_addr", imem.addr, 32'h0000_0000);
    repeat (8) cycle();

    // Randomized traffic against the reference model.
    for (int blk = 0; blk < 10; blk++) begin
      lat_min   = $urandom_range(1, 3);
      lat_extra = $urandom_range(0, 2);
      for (int i = 0; i < 200; i++) begin
        start_i       = ($urandom_range(0, 9) != 0);
        stall_i       = ($urandom_range(0, 9) < 3);
        flush_i       = ($urandom_range(0, 19) == 0);
        redirect_pc_i = $urandom;
        rst_i         = ($urandom_range(0, 199) != 0);
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
